// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_pkg
// Brief    : Shared types and idle-level helpers for the segment scan driver.
// Revision : 1.0
// ============================================================================
package seg_scan_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;
    typedef logic [7:0] seg_t;

    function automatic seg_t seg_off(input logic inv);
        return inv ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] dig_off(input logic inv);
        return inv ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : seg_slot_timer
// Brief    : Tick counter within a digit slot and digit index across a frame.
// Revision : 1.0
// ============================================================================
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_TICKS = 1000,
    parameter int TICK_W      = $clog2(DIGIT_TICKS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [TICK_W-1:0] tick,
    output digit_idx_t        idx,
    output logic              slot_start,
    output logic              frame_start_pre
);

    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(DIGIT_TICKS - 1);
    localparam digit_idx_t        c_idx_last  = digit_idx_t'(NUM_DIGITS - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    digit_idx_t        idx_q, idx_d;

    always_comb begin
        tick_d = tick_q + 1'b1;
        idx_d  = idx_q;
        if (tick_q == c_tick_last) begin
            tick_d = '0;
            idx_d  = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            idx_q  <= '0;
        end else begin
            tick_q <= tick_d;
            idx_q  <= idx_d;
        end
    end

    assign tick            = tick_q;
    assign idx             = idx_q;
    assign slot_start      = (tick_q == '0);
    assign frame_start_pre = (tick_q == '0) && (idx_q == '0);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Six-digit multiplexed segment driver with blanking and PWM dimming.
// Revision : 1.0
// ============================================================================
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_TICKS = 1000,
    parameter int BLANK_TICKS = 50,
    parameter int SEG_INV     = 0,
    parameter int DIG_INV     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            d5,
    input  logic [7:0]            d4,
    input  logic [7:0]            d3,
    input  logic [7:0]            d2,
    input  logic [7:0]            d1,
    input  logic [7:0]            d0,
    input  logic [2:0]            brightness,
    input  logic                  en,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig,
    output logic                  frame_start
);

    localparam int TICK_W = $clog2(DIGIT_TICKS) + 1;

    localparam logic [TICK_W-1:0]     c_blank    = TICK_W'(BLANK_TICKS);
    localparam logic [TICK_W-1:0]     c_on_step  = TICK_W'((DIGIT_TICKS - BLANK_TICKS) >> 3);
    localparam seg_t                  c_seg_off  = seg_off(SEG_INV != 0);
    localparam logic [NUM_DIGITS-1:0] c_dig_off  = dig_off(DIG_INV != 0);
    localparam logic [NUM_DIGITS-1:0] c_dig_one  = NUM_DIGITS'(1);

    logic [TICK_W-1:0] tick;
    digit_idx_t        idx;
    logic              slot_start;
    logic              frame_start_pre;

    seg_slot_timer #(
        .DIGIT_TICKS (DIGIT_TICKS),
        .TICK_W      (TICK_W)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .tick            (tick),
        .idx             (idx),
        .slot_start      (slot_start),
        .frame_start_pre (frame_start_pre)
    );

    seg_t d_in [NUM_DIGITS];
    assign d_in[0] = d0;
    assign d_in[1] = d1;
    assign d_in[2] = d2;
    assign d_in[3] = d3;
    assign d_in[4] = d4;
    assign d_in[5] = d5;

    seg_t                  shadow_q [NUM_DIGITS];
    seg_t                  shadow_d [NUM_DIGITS];
    logic [2:0]            bright_q, bright_d;
    logic [TICK_W-1:0]     on_len;
    logic                  lit;
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_start_q, frame_start_d;

    // Patterns are only sampled at the frame boundary so a digit is stable for a whole frame.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_d[i] = frame_start_pre ? d_in[i] : shadow_q[i];
        end
        bright_d      = slot_start ? brightness : bright_q;
        frame_start_d = frame_start_pre;
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
            always_ff @(posedge clk or posedge rst) begin
                if (rst) shadow_q[gi] <= '0;
                else     shadow_q[gi] <= shadow_d[gi];
            end
        end
    endgenerate

    always_comb begin
        on_len = c_on_step * TICK_W'({1'b0, bright_q} + 4'd1);
        lit    = en && (tick >= c_blank) && ((tick - c_blank) < on_len);
        seg_d  = c_seg_off;
        dig_d  = c_dig_off;
        if (lit) begin
            seg_d = (SEG_INV != 0) ? ~shadow_q[idx] : shadow_q[idx];
            dig_d = c_dig_off ^ (c_dig_one << idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright_q      <= '0;
            seg_q         <= c_seg_off;
            dig_q         <= c_dig_off;
            frame_start_q <= 1'b0;
        end else begin
            bright_q      <= bright_d;
            seg_q         <= seg_d;
            dig_q         <= dig_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dig         = dig_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed self-checking bench for seg_scan_driver (20-tick slots).
// Revision : 1.0
// ============================================================================
module tb_seg_scan_driver;

    localparam int DT    = 20;
    localparam int FRAME = 6 * DT;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d5, d4, d3, d2, d1, d0;
    logic [2:0] brightness;
    logic       en;
    logic [7:0] seg;
    logic [5:0] dig;
    logic       frame_start;

    int n_vec = 0;
    int n_err = 0;
    int ec;
    logic [7:0] exp_sh [6];

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGIT_TICKS (20),
        .BLANK_TICKS (2),
        .SEG_INV     (0),
        .DIG_INV     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d5          (d5),
        .d4          (d4),
        .d3          (d3),
        .d2          (d2),
        .d1          (d1),
        .d0          (d0),
        .brightness  (brightness),
        .en          (en),
        .seg         (seg),
        .dig         (dig),
        .frame_start (frame_start)
    );

    // Edges since reset release; edge k processes frame position k-1.
    always @(posedge clk or posedge rst) begin
        if (rst) ec <= 0;
        else     ec <= ec + 1;
    end

    function automatic logic [13:0] exp_out(int e, int b, bit en_v);
        int pos, idx, t;
        bit lit;
        logic [5:0] dg;
        logic [7:0] sg;
        pos = (e - 1) % FRAME;
        idx = pos / DT;
        t   = pos % DT;
        lit = en_v && (t >= 2) && ((t - 2) < 2 * (b + 1));
        dg  = lit ? ~(6'd1 << idx) : 6'h3F;
        sg  = lit ? exp_sh[idx] : 8'h00;
        return {dg, sg};
    endfunction

    // Continuous invariants: one digit at most, and a dark gap between digits.
    int mon_last = -1;
    int mon_dark = 0;
    int mon_cur;
    always @(negedge clk) begin
        n_vec++;
        if ($countones(~dig) > 1) begin
            n_err++;
            $display("FAIL onehot: dig=%b, required at most one active digit", dig);
        end
        if ($countones(~dig) == 1) begin
            mon_cur = 0;
            for (int i = 0; i < 6; i++) if (!dig[i]) mon_cur = i;
            if (mon_last != -1 && mon_cur != mon_last) begin
                n_vec++;
                if (mon_dark < 2) begin
                    n_err++;
                    $display("FAIL blank_gap: %0d dark cycles, required >= 2", mon_dark);
                end
            end
            mon_last = mon_cur;
            mon_dark = 0;
        end else begin
            mon_dark++;
        end
    end

    task automatic wait_frame();
        bit found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: no frame_start within 200 cycles, required one");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; brightness = 3'd7;
        d5 = 8'h6D; d4 = 8'h66; d3 = 8'h4F; d2 = 8'h5B; d1 = 8'h06; d0 = 8'h3F;
        exp_sh[0] = 8'h3F; exp_sh[1] = 8'h06; exp_sh[2] = 8'h5B;
        exp_sh[3] = 8'h4F; exp_sh[4] = 8'h66; exp_sh[5] = 8'h6D;
        repeat (3) @(negedge clk);
        n_vec++; if (dig !== 6'h3F) begin n_err++; $display("FAIL reset_dig: got %h want 3f", dig); end
        n_vec++; if (seg !== 8'h00) begin n_err++; $display("FAIL reset_seg: got %h want 00", seg); end
        n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        rst = 1'b0;
    endtask

    task automatic test_basic_scan();
        logic [13:0] e;
        repeat (2 * FRAME) begin
            @(negedge clk);
            e = exp_out(ec, 7, 1);
            n_vec++;
            if ({dig, seg} !== e) begin
                n_err++;
                $display("FAIL basic_out ec=%0d: got dig=%h seg=%h want dig=%h seg=%h", ec, dig, seg, e[13:8], e[7:0]);
            end
            n_vec++;
            if (frame_start !== ((ec - 1) % FRAME == 0)) begin
                n_err++;
                $display("FAIL basic_fs ec=%0d: got %b want %b", ec, frame_start, ((ec - 1) % FRAME == 0));
            end
        end
    endtask

    task automatic test_tear_free();
        logic [13:0] e;
        wait_frame();
        repeat (FRAME - 1) begin
            @(negedge clk);
            e = exp_out(ec, 7, 1);
            n_vec++;
            if ({dig, seg} !== e) begin
                n_err++;
                $display("FAIL tear_old ec=%0d: got dig=%h seg=%h want dig=%h seg=%h", ec, dig, seg, e[13:8], e[7:0]);
            end
            if ((ec - 1) % FRAME == 50) d3 = 8'h7F;
        end
        exp_sh[3] = 8'h7F;
        repeat (FRAME) begin
            @(negedge clk);
            e = exp_out(ec, 7, 1);
            n_vec++;
            if ({dig, seg} !== e) begin
                n_err++;
                $display("FAIL tear_new ec=%0d: got dig=%h seg=%h want dig=%h seg=%h", ec, dig, seg, e[13:8], e[7:0]);
            end
        end
    endtask

    task automatic test_brightness();
        int cnt [6];
        brightness = 3'd0;
        wait_frame();
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        repeat (FRAME - 1) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) if (dig === ~(6'd1 << i)) cnt[i]++;
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (cnt[i] != 2) begin
                n_err++;
                $display("FAIL bright_min digit %0d: got %0d lit cycles want 2", i, cnt[i]);
            end
        end
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        repeat (2 * DT) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) if (dig === ~(6'd1 << i)) cnt[i]++;
            if ((ec - 1) % FRAME == 10) brightness = 3'd7;
        end
        n_vec++;
        if (cnt[0] != 2) begin n_err++; $display("FAIL bright_hold: got %0d lit cycles want 2", cnt[0]); end
        n_vec++;
        if (cnt[1] != 16) begin n_err++; $display("FAIL bright_next: got %0d lit cycles want 16", cnt[1]); end
    endtask

    task automatic test_enable();
        logic [13:0] e;
        wait_frame();
        en = 1'b0;
        repeat (FRAME) begin
            @(negedge clk);
            n_vec++;
            if (dig !== 6'h3F || seg !== 8'h00) begin
                n_err++;
                $display("FAIL en_dark ec=%0d: got dig=%h seg=%h want dig=3f seg=00", ec, dig, seg);
            end
            n_vec++;
            if (frame_start !== ((ec - 1) % FRAME == 0)) begin
                n_err++;
                $display("FAIL en_fs ec=%0d: got %b want %b", ec, frame_start, ((ec - 1) % FRAME == 0));
            end
        end
        en = 1'b1;
        repeat (FRAME) begin
            @(negedge clk);
            e = exp_out(ec, 7, 1);
            n_vec++;
            if ({dig, seg} !== e) begin
                n_err++;
                $display("FAIL en_resume ec=%0d: got dig=%h seg=%h want dig=%h seg=%h", ec, dig, seg, e[13:8], e[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((ec - 1) % FRAME == 45) break;
        end
        n_vec++;
        if (dig !== 6'h3B) begin n_err++; $display("FAIL mid_pre: got dig=%h want 3b", dig); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (dig !== 6'h3F) begin n_err++; $display("FAIL mid_dig_async: got %h want 3f", dig); end
        n_vec++; if (seg !== 8'h00) begin n_err++; $display("FAIL mid_seg_async: got %h want 00", seg); end
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (frame_start !== 1'b0 || dig !== 6'h3F) begin
                n_err++;
                $display("FAIL mid_hold: got fs=%b dig=%h want fs=0 dig=3f", frame_start, dig);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ec == 1) begin
                n_vec++;
                if (frame_start !== 1'b1) begin n_err++; $display("FAIL mid_fs: got %b want 1", frame_start); end
            end
            if (dig !== 6'h3F) begin
                found = 1;
                n_vec++;
                if (dig !== 6'h3E || seg !== exp_sh[0] || ec != 3) begin
                    n_err++;
                    $display("FAIL mid_first: got dig=%h seg=%h ec=%0d want dig=3e seg=%h ec=3", dig, seg, ec, exp_sh[0]);
                end
                break;
            end
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL mid_timeout: no digit lit within 30 cycles, required digit 0");
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_brightness();
        test_enable();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
